exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage directly downstream of the decode pipeline registers; consumes their registered operands and control bits.
- Single-cycle ALU for ADD/SUB/PASS; a MUL_STAGES-deep pipelined multiplier for MUL.
- Produces the `execution_empty` flag that gates decode-register updates.
- Registers results toward the memory stage.

Parameters:
- WORD_WIDTH, 32, datapath width.
- REGISTER_INDEX_WIDTH, 5, register index width.
- OFFSET_SIZE, 15, immediate/offset width; sign-extended to WORD_WIDTH.
- MUL_STAGES, 5, multiplier latency in cycles; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- valid_in  in  1  decode registers hold a real instruction (0 = bubble/NOP).
- alu_op_in  in  2  00 ADD, 01 SUB, 10 MUL, 11 PASS (result = operand B).
- alu_src_in  in  1  1: operand B = sext(offset_in); 0: B = second_input_in.
- first_input_in  in  WORD_WIDTH  operand A.
- second_input_in  in  WORD_WIDTH  register operand B; also store data.
- offset_in  in  OFFSET_SIZE  immediate.
- destination_register_in  in  REGISTER_INDEX_WIDTH  write-back index.
- reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in  in  1 each  control, passed through.
- stall_in  in  1  memory stage cannot accept.
- flush_in  in  1  kill in-flight and incoming work.
- valid_out  out  1  result registers hold a completed op this cycle.
- result_out  out  WORD_WIDTH  ALU/MUL result or address.
- store_data_out  out  WORD_WIDTH  second_input_in captured at accept.
- destination_register_out  out  REGISTER_INDEX_WIDTH.
- reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out  out  1 each.
- execution_empty  out  1  no multi-cycle op in flight; registered.

Behaviour:
- Reset (rst_n=0, async): all outputs 0 except execution_empty=1; multiplier pipeline valid bits cleared; FSM to IDLE. Deasserting reset mid-MUL discards the MUL.

Accept rule:
- Inputs are accepted at a posedge when valid_in=1, execution_empty=1, stall_in=0 and flush_in=0.
- When valid_in=0 at such an edge, a bubble is registered: valid_out=0, all control outputs 0.

FSM:
- IDLE -> IDLE on accept of ADD/SUB/PASS.
  - Outputs registered at the same edge (latency 1).
  - ADD/SUB results wrap modulo 2^WORD_WIDTH; no flags.
- IDLE -> MUL_BUSY on accept of MUL.
  - At that edge: execution_empty<=0, valid_out<=0.
  - Control/dest/store_data are held internally.
- MUL_BUSY: down-counter from MUL_STAGES-1.
  - The counter and pipeline advance only when stall_in=0.
  - Counter reaching 0 -> IDLE. At that same edge:
    - result_out = low WORD_WIDTH bits of A*B;
    - valid_out=1 for one cycle;
    - execution_empty<=1.
  - MUL result is therefore visible MUL_STAGES edges after the accept edge when unstalled.
- A new op is never accepted while in MUL_BUSY. The transition edge back to IDLE does not also accept.

Stall and flush:
- stall_in=1: every output register and the multiplier pipeline hold; no accept.
- flush_in=1 (priority over stall and accept):
  - Next edge: valid_out=0, control outputs 0, execution_empty=1, FSM to IDLE.
  - In-flight MUL is discarded; input at that edge is dropped.

Boundary rules:
- MUL with operand 0 or all-ones follows the same latency.
- Back-to-back MULs are separated by at least one IDLE edge, because upstream sees execution_empty=1 only after completion.
- Bubbles never set execution_empty=0.

Optional Feature:
- Macro EXEC_STALL_COUNTER_EN.
- When defined:
  - Adds output mul_stall_cycles[31:0], reset 0.
  - Increments on every posedge where state=MUL_BUSY and flush_in=0; saturates at all-ones.
- When undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: ALU_OP_ADD/SUB/MUL/PASS encodings, NOP_INSTRUCTION, FSM state encodings, width parameters already in the common parameters include.
- One sub-module, mul_pipeline:
  - MUL_STAGES-deep registered multiplier with per-stage valid;
  - advance and flush inputs; result_valid output.
- exec_stage owns the FSM, ALU, operand mux and output registers.

Test Plan:
- Reset mid-MUL: accept MUL, drop rst_n two cycles later -> all outputs 0, execution_empty=1, no valid_out afterward.
- ADD: A=7, B=5, alu_src=0, dest=3, reg_write=1 -> next edge valid_out=1, result_out=12, destination_register_out=3, execution_empty stays 1.
- SUB with immediate: A=0, offset=15'h7FFF (-1), alu_src=1 -> result_out=1. ADD with A=32'hFFFFFFFF, B=1 -> result_out=0 (wrap).
- MUL: A=6, B=7 -> execution_empty=0 for 5 edges, valid_out=1 with result_out=42 at edge 5. Inputs changed during busy are ignored.
- Stall during MUL: stall_in=1 for 3 cycles mid-op -> result at edge 8, outputs held during stall. With EXEC_STALL_COUNTER_EN, mul_stall_cycles=8.
- Flush during MUL at edge 2 -> valid_out never asserts for that MUL, execution_empty=1 next edge. A following ADD 1+1 -> result_out=2 one edge after accept.

Source files
------------

// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: shared ALU encodings, FSM states and default widths for the execute stage.
package exec_stage_pkg;

    localparam int WORD_WIDTH_DEF           = 32;
    localparam int REGISTER_INDEX_WIDTH_DEF = 5;
    localparam int OFFSET_SIZE_DEF          = 15;
    localparam int MUL_STAGES_DEF           = 5;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_MUL  = 2'b10;
    localparam logic [1:0] ALU_OP_PASS = 2'b11;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } exec_state_e;

endpackage

// File: rtl/exec_stage_mul_pipeline.sv
// exec_stage_mul_pipeline: MUL_STAGES-deep registered multiplier with a valid bit per stage.
module exec_stage_mul_pipeline #(
    parameter int WORD_WIDTH = 32,
    parameter int MUL_STAGES = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  advance,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] operand_a,
    input  logic [WORD_WIDTH-1:0] operand_b,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  result_valid
);

    logic [WORD_WIDTH-1:0] product_s;
    logic [WORD_WIDTH-1:0] stage_data_r [MUL_STAGES];
    logic [MUL_STAGES-1:0] stage_valid_r;

    assign product_s = operand_a * operand_b;

    // Shift register of partial results; only the low word of the product is ever needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_r <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                stage_data_r[i] <= '0;
            end
        end else if (flush) begin
            stage_valid_r <= '0;
        end else if (advance) begin
            stage_valid_r   <= {stage_valid_r[MUL_STAGES-2:0], start};
            stage_data_r[0] <= product_s;
            for (int i = 1; i < MUL_STAGES; i++) begin
                stage_data_r[i] <= stage_data_r[i-1];
            end
        end else begin
            stage_valid_r <= stage_valid_r;
        end
    end

    assign result       = stage_data_r[MUL_STAGES-1];
    assign result_valid = stage_valid_r[MUL_STAGES-1];

endmodule

// File: rtl/exec_stage.sv
// exec_stage: single-cycle ALU plus pipelined MUL, registered toward the memory stage.
// Build macro EXEC_STALL_COUNTER_EN adds the mul_stall_cycles output.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int WORD_WIDTH           = WORD_WIDTH_DEF,
    parameter int REGISTER_INDEX_WIDTH = REGISTER_INDEX_WIDTH_DEF,
    parameter int OFFSET_SIZE          = OFFSET_SIZE_DEF,
    parameter int MUL_STAGES           = MUL_STAGES_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [1:0]                      alu_op_in,
    input  logic                            alu_src_in,
    input  logic [WORD_WIDTH-1:0]           first_input_in,
    input  logic [WORD_WIDTH-1:0]           second_input_in,
    input  logic [OFFSET_SIZE-1:0]          offset_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
    input  logic                            reg_write_in,
    input  logic                            d_cache_access_in,
    input  logic                            d_cache_op_in,
    input  logic                            is_byte_op_in,
    input  logic                            stall_in,
    input  logic                            flush_in,
    output logic                            valid_out,
    output logic [WORD_WIDTH-1:0]           result_out,
    output logic [WORD_WIDTH-1:0]           store_data_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
    output logic                            reg_write_out,
    output logic                            d_cache_access_out,
    output logic                            d_cache_op_out,
    output logic                            is_byte_op_out,
    output logic                            execution_empty
`ifdef EXEC_STALL_COUNTER_EN
    ,
    output logic [31:0]                     mul_stall_cycles
`endif
);

    localparam int CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    exec_state_e                     state_r, state_s;
    logic [CNT_W-1:0]                cnt_r, cnt_s;
    logic                            mul_start_s, mul_done_s, idle_update_s;
    logic [WORD_WIDTH-1:0]           operand_b_s, alu_result_s, mul_result_s;
    logic                            mul_result_valid_s;
    logic [WORD_WIDTH-1:0]           held_store_r;
    logic [REGISTER_INDEX_WIDTH-1:0] held_dest_r;
    logic [3:0]                      held_ctrl_r;

    // Operand B: register value or sign-extended immediate.
    always_comb begin
        operand_b_s = second_input_in;
        if (alu_src_in) begin
            operand_b_s = {{(WORD_WIDTH-OFFSET_SIZE){offset_in[OFFSET_SIZE-1]}}, offset_in};
        end else begin
            operand_b_s = second_input_in;
        end
    end

    // Single-cycle ALU; MUL results come from the pipeline instead.
    always_comb begin
        alu_result_s = '0;
        case (alu_op_in)
            ALU_OP_ADD:  alu_result_s = first_input_in + operand_b_s;
            ALU_OP_SUB:  alu_result_s = first_input_in - operand_b_s;
            ALU_OP_PASS: alu_result_s = operand_b_s;
            default:     alu_result_s = '0;
        endcase
    end

    // Next state and MUL down-counter; flush wins over stall and accept.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        mul_start_s   = 1'b0;
        mul_done_s    = 1'b0;
        idle_update_s = 1'b0;
        if (flush_in) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idle_update_s = ~stall_in;
                    if (!stall_in && valid_in && (alu_op_in == ALU_OP_MUL)) begin
                        state_s     = ST_MUL_BUSY;
                        cnt_s       = CNT_START;
                        mul_start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MUL_BUSY: begin
                    if (stall_in) begin
                        state_s = ST_MUL_BUSY;
                    end else if (cnt_r == '0) begin
                        state_s    = ST_IDLE;
                        mul_done_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    exec_stage_mul_pipeline #(
        .WORD_WIDTH (WORD_WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_pipeline (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start_s),
        .advance      (~stall_in),
        .flush        (flush_in),
        .operand_a    (first_input_in),
        .operand_b    (operand_b_s),
        .result       (mul_result_s),
        .result_valid (mul_result_valid_s)
    );

    // Memory-stage output registers and the MUL side-band held until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {valid_out, result_out, store_data_out, destination_register_out,
             reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <= '0;
            execution_empty <= 1'b1;
            held_store_r    <= '0;
            held_dest_r     <= '0;
            held_ctrl_r     <= 4'b0000;
        end else if (flush_in) begin
            {valid_out, result_out, store_data_out, destination_register_out,
             reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <= '0;
            execution_empty <= 1'b1;
        end else if (mul_done_s) begin
            valid_out                <= mul_result_valid_s;
            result_out               <= mul_result_s;
            store_data_out           <= held_store_r;
            destination_register_out <= held_dest_r;
            {reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <= held_ctrl_r;
            execution_empty          <= 1'b1;
        end else if (mul_start_s) begin
            {valid_out, result_out, store_data_out, destination_register_out,
             reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <= '0;
            execution_empty <= 1'b0;
            held_store_r    <= second_input_in;
            held_dest_r     <= destination_register_in;
            held_ctrl_r     <= {reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in};
        end else if (idle_update_s && valid_in) begin
            valid_out                <= 1'b1;
            result_out               <= alu_result_s;
            store_data_out           <= second_input_in;
            destination_register_out <= destination_register_in;
            {reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <=
                {reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in};
        end else if (idle_update_s) begin
            {valid_out, result_out, store_data_out, destination_register_out,
             reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out} <= '0;
        end else begin
            execution_empty <= execution_empty;
        end
    end

`ifdef EXEC_STALL_COUNTER_EN
    // Saturating count of edges spent with a MUL in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_stall_cycles <= 32'd0;
        end else if ((state_r == ST_MUL_BUSY) && !flush_in && (mul_stall_cycles != 32'hFFFF_FFFF)) begin
            mul_stall_cycles <= mul_stall_cycles + 32'd1;
        end else begin
            mul_stall_cycles <= mul_stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: vector table, hand-written MUL/stall/flush/reset sequences and a random run
// checked against a transaction-level model of the execute stage.
module tb_exec_stage;

    localparam int WW = 32;
    localparam int RW = 5;
    localparam int OW = 15;
    localparam int MS = 5;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, valid_in, alu_src_in, stall_in, flush_in;
    logic [1:0]    alu_op_in;
    logic [WW-1:0] first_input_in, second_input_in;
    logic [OW-1:0] offset_in;
    logic [RW-1:0] destination_register_in;
    logic          reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in;
    logic          valid_out, reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out;
    logic          execution_empty;
    logic [WW-1:0] result_out, store_data_out;
    logic [RW-1:0] destination_register_out;
    logic [3:0]    ctrl_out;
`ifdef EXEC_STALL_COUNTER_EN
    logic [31:0]   mul_stall_cycles;
    logic [31:0]   stall_cnt_before;
`endif

    assign ctrl_out = {reg_write_out, d_cache_access_out, d_cache_op_out, is_byte_op_out};

    exec_stage #(.WORD_WIDTH(WW), .REGISTER_INDEX_WIDTH(RW), .OFFSET_SIZE(OW), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op_in(alu_op_in), .alu_src_in(alu_src_in),
        .first_input_in(first_input_in), .second_input_in(second_input_in), .offset_in(offset_in),
        .destination_register_in(destination_register_in), .reg_write_in(reg_write_in),
        .d_cache_access_in(d_cache_access_in), .d_cache_op_in(d_cache_op_in),
        .is_byte_op_in(is_byte_op_in), .stall_in(stall_in), .flush_in(flush_in),
        .valid_out(valid_out), .result_out(result_out), .store_data_out(store_data_out),
        .destination_register_out(destination_register_out), .reg_write_out(reg_write_out),
        .d_cache_access_out(d_cache_access_out), .d_cache_op_out(d_cache_op_out),
        .is_byte_op_out(is_byte_op_out), .execution_empty(execution_empty)
`ifdef EXEC_STALL_COUNTER_EN
        , .mul_stall_cycles(mul_stall_cycles)
`endif
    );

    int checks_total = 0;
    int checks_passed = 0;

    typedef struct packed {
        logic [1:0]    op;
        logic          src;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [OW-1:0] off;
        logic [RW-1:0] dest;
        logic [3:0]    ctrl;
        logic [WW-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    // model state
    logic          m_busy, m_valid, m_empty, m_ctrl_known;
    int            m_left;
    logic [WW-1:0] m_result, m_store, p_result, p_store;
    logic [RW-1:0] m_dest, p_dest;
    logic [3:0]    m_ctrl, p_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else checks_passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic src, input logic [WW-1:0] a,
                         input logic [WW-1:0] b, input logic [OW-1:0] off,
                         input logic [RW-1:0] d, input logic [3:0] c);
        valid_in = 1'b1; alu_op_in = op; alu_src_in = src;
        first_input_in = a; second_input_in = b; offset_in = off;
        destination_register_in = d;
        {reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in} = c;
    endtask

    task automatic go_idle();
        drive(OP_ADD, 1'b0, 32'd0, 32'd0, 15'd0, 5'd0, 4'b0000);
        valid_in = 1'b0;
    endtask

    function automatic logic [WW-1:0] ref_b(input logic src, input logic [WW-1:0] b, input logic [OW-1:0] off);
        int v;
        v = $signed(off);
        return src ? WW'(v) : b;
    endfunction

    function automatic logic [WW-1:0] ref_op(input logic [1:0] op, input logic [WW-1:0] a, input logic [WW-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[31:0];
            default: return b;
        endcase
    endfunction

    function automatic logic [WW-1:0] pick();
        case ($urandom_range(3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_valid = 1'b0; m_empty = 1'b1; m_ctrl_known = 1'b1; m_left = 0;
        m_ctrl = 4'b0000; m_result = 32'd0; m_store = 32'd0; m_dest = 5'd0;
    endtask

    // one posedge worth of transaction-level behaviour, using the inputs presented at that edge
    task automatic model_edge();
        logic [3:0] c;
        c = {reg_write_in, d_cache_access_in, d_cache_op_in, is_byte_op_in};
        if (flush_in) begin
            m_busy = 1'b0; m_valid = 1'b0; m_ctrl = 4'b0000; m_ctrl_known = 1'b1; m_empty = 1'b1;
        end else if (m_busy) begin
            if (!stall_in) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1; m_empty = 1'b1; m_ctrl_known = 1'b1;
                    m_result = p_result; m_store = p_store; m_dest = p_dest; m_ctrl = p_ctrl;
                end
            end
        end else if (!stall_in) begin
            if (!valid_in) begin
                m_valid = 1'b0; m_ctrl = 4'b0000; m_ctrl_known = 1'b1;
            end else if (alu_op_in == OP_MUL) begin
                m_busy = 1'b1; m_left = MS; m_valid = 1'b0; m_empty = 1'b0; m_ctrl_known = 1'b0;
                p_result = ref_op(OP_MUL, first_input_in, ref_b(alu_src_in, second_input_in, offset_in));
                p_store = second_input_in; p_dest = destination_register_in; p_ctrl = c;
            end else begin
                m_valid = 1'b1; m_ctrl = c; m_ctrl_known = 1'b1;
                m_result = ref_op(alu_op_in, first_input_in, ref_b(alu_src_in, second_input_in, offset_in));
                m_store = second_input_in; m_dest = destination_register_in;
            end
        end
    endtask

    task automatic run_mul(input string name, input logic [WW-1:0] a, input logic [WW-1:0] b,
                           input logic [WW-1:0] exp);
        drive(OP_MUL, 1'b0, a, b, 15'd0, 5'd9, 4'b1000);
        step();
        check({name, "_accept_valid"}, 32'(valid_out), 32'd0);
        check({name, "_accept_empty"}, 32'(execution_empty), 32'd0);
        drive(OP_ADD, 1'b0, 32'd1, 32'd2, 15'd0, 5'd1, 4'b1111);
        for (int k = 1; k < MS; k++) begin
            step();
            check({name, "_busy_empty"}, 32'(execution_empty), 32'd0);
            check({name, "_busy_valid"}, 32'(valid_out), 32'd0);
        end
        step();
        check({name, "_done_valid"}, 32'(valid_out), 32'd1);
        check({name, "_done_result"}, result_out, exp);
        check({name, "_done_empty"}, 32'(execution_empty), 32'd1);
        check({name, "_done_dest"}, 32'(destination_register_out), 32'd9);
        check({name, "_done_store"}, store_data_out, b);
        check({name, "_done_ctrl"}, 32'(ctrl_out), 32'h8);
        go_idle();
        step();
        check({name, "_bubble_valid"}, 32'(valid_out), 32'd0);
        check({name, "_bubble_ctrl"}, 32'(ctrl_out), 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_ADD,  1'b0, 32'd7,          32'd5,          15'h0000, 5'd3,  4'b1000, 32'd12};
        vecs[1] = '{OP_SUB,  1'b1, 32'd0,          32'h0000_1234,  15'h7FFF, 5'd1,  4'b1000, 32'd1};
        vecs[2] = '{OP_ADD,  1'b0, 32'hFFFF_FFFF,  32'd1,          15'h0000, 5'd31, 4'b1111, 32'd0};
        vecs[3] = '{OP_SUB,  1'b0, 32'd5,          32'd7,          15'h0000, 5'd2,  4'b0100, 32'hFFFF_FFFE};
        vecs[4] = '{OP_PASS, 1'b1, 32'd55,         32'h0000_AAAA,  15'h4000, 5'd4,  4'b0110, 32'hFFFF_C000};
        vecs[5] = '{OP_PASS, 1'b0, 32'd1,          32'hDEAD_BEEF,  15'h0000, 5'd5,  4'b0001, 32'hDEAD_BEEF};
        vecs[6] = '{OP_ADD,  1'b1, 32'd100,        32'd0,          15'h0010, 5'd6,  4'b1010, 32'd116};

        rst_n = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        go_idle();
        #2 rst_n = 1'b0;
        #1;
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_result", result_out, 32'd0);
        check("reset_ctrl", 32'(ctrl_out), 32'd0);
        check("reset_empty", 32'(execution_empty), 32'd1);
        step();
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].dest, vecs[i].ctrl);
            step();
            check("vec_valid", 32'(valid_out), 32'd1);
            check("vec_result", result_out, vecs[i].exp);
            check("vec_dest", 32'(destination_register_out), 32'(vecs[i].dest));
            check("vec_store", store_data_out, vecs[i].b);
            check("vec_ctrl", 32'(ctrl_out), 32'(vecs[i].ctrl));
            check("vec_empty", 32'(execution_empty), 32'd1);
        end

        run_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
        run_mul("mul_zero", 32'd0, 32'h1234_5678, 32'd0);
        run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

        // stall for three edges in the middle of a MUL
`ifdef EXEC_STALL_COUNTER_EN
        stall_cnt_before = mul_stall_cycles;
`endif
        drive(OP_MUL, 1'b0, 32'd9, 32'd11, 15'd0, 5'd7, 4'b1000);
        step();
        go_idle();
        for (int e = 1; e <= 7; e++) begin
            stall_in = (e >= 3 && e <= 5);
            step();
            check("stall_busy_valid", 32'(valid_out), 32'd0);
            check("stall_busy_empty", 32'(execution_empty), 32'd0);
        end
        stall_in = 1'b0;
        step();
        check("stall_done_valid", 32'(valid_out), 32'd1);
        check("stall_done_result", result_out, 32'd99);
        check("stall_done_empty", 32'(execution_empty), 32'd1);
`ifdef EXEC_STALL_COUNTER_EN
        check("stall_counter", mul_stall_cycles - stall_cnt_before, 32'd8);
`endif
        stall_in = 1'b1;
        step();
        check("stall_hold_valid", 32'(valid_out), 32'd1);
        check("stall_hold_result", result_out, 32'd99);
        stall_in = 1'b0;
        step();
        check("stall_release_bubble", 32'(valid_out), 32'd0);

        // flush on the second edge of a MUL, then a plain ADD
        drive(OP_MUL, 1'b0, 32'd3, 32'd4, 15'd0, 5'd8, 4'b1000);
        step();
        go_idle();
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_empty", 32'(execution_empty), 32'd1);
        check("flush_ctrl", 32'(ctrl_out), 32'd0);
        drive(OP_ADD, 1'b0, 32'd1, 32'd1, 15'd0, 5'd2, 4'b1000);
        step();
        check("flush_add_valid", 32'(valid_out), 32'd1);
        check("flush_add_result", result_out, 32'd2);
        go_idle();
        for (int k = 0; k < 8; k++) begin
            step();
            check("flush_no_late_mul", 32'(valid_out), 32'd0);
        end

        // reset two cycles into a MUL
        drive(OP_MUL, 1'b0, 32'd5, 32'd5, 15'd0, 5'd3, 4'b1111);
        step();
        go_idle();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mul_valid", 32'(valid_out), 32'd0);
        check("rst_mul_empty", 32'(execution_empty), 32'd1);
        check("rst_mul_ctrl", 32'(ctrl_out), 32'd0);
        check("rst_mul_dest", 32'(destination_register_out), 32'd0);
        check("rst_mul_store", store_data_out, 32'd0);
        step();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rst_mul_no_valid", 32'(valid_out), 32'd0);
            check("rst_mul_idle_empty", 32'(execution_empty), 32'd1);
        end

        // random run against the model, starting from a fresh reset
        rst_n = 1'b0;
        model_reset();
        step();
        #3 rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            drive(2'($urandom_range(3)), 1'($urandom_range(1)), pick(), pick(), 15'($urandom),
                  5'($urandom), 4'($urandom));
            valid_in = ($urandom_range(9) < 7);
            stall_in = ($urandom_range(6) == 0);
            flush_in = ($urandom_range(29) == 0);
            @(posedge clk);
            model_edge();
            #1;
            check("rnd_valid", 32'(valid_out), 32'(m_valid));
            check("rnd_empty", 32'(execution_empty), 32'(m_empty));
            if (m_valid) begin
                check("rnd_result", result_out, m_result);
                check("rnd_dest", 32'(destination_register_out), 32'(m_dest));
                check("rnd_store", store_data_out, m_store);
            end
            if (m_ctrl_known) check("rnd_ctrl", 32'(ctrl_out), 32'(m_ctrl));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
